// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port round-robin arbiter and read sequencer in front of
// the single-port sram wrapper. One access is issued per cycle. Read returns
// are tracked through a fixed-latency pipeline and tagged to their owner.
module sram_arbiter #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 8,
    parameter int READ_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  mem_we,
    output logic                  mem_oe,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  busy
);

    // last_b = 1 means port B holds the most recent grant, so A wins a tie.
    logic                    last_b;
    logic                    issue_rd;
    logic                    ret_vld;
    // Read-tracking pipeline: index k holds the read issued k+1 cycles ago.
    // own_p = 1 marks a read owned by port B.
    logic [READ_LATENCY-1:0] vld_p;
    logic [READ_LATENCY-1:0] own_p;

    // Round-robin grant; reset overrides any request.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (!rst) begin
            a_gnt = a_req && (!b_req || last_b);
            b_gnt = b_req && (!a_req || !last_b);
        end
    end

    // Drive the sram port straight from the winning requester.
    always_comb begin
        mem_we   = 1'b0;
        mem_addr = '0;
        mem_din  = '0;
        issue_rd = 1'b0;
        if (a_gnt) begin
            mem_we   = a_we;
            mem_addr = a_addr;
            mem_din  = a_wdata;
            issue_rd = !a_we;
        end else if (b_gnt) begin
            mem_we   = b_we;
            mem_addr = b_addr;
            mem_din  = b_wdata;
            issue_rd = !b_we;
        end
    end

    // Control state: fairness pointer and read-valid pipeline.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_b <= 1'b1;
            vld_p  <= '0;
        end else begin
            if (a_gnt || b_gnt)
                last_b <= b_gnt;
            vld_p <= {vld_p[READ_LATENCY-2:0], issue_rd};
        end
    end

    // Owner tag travels with the valid bit; it is meaningless when invalid,
    // so it needs no reset.
    always_ff @(posedge clk) begin
        own_p <= {own_p[READ_LATENCY-2:0], b_gnt};
    end

    // Output enable one cycle before return, when the wrapper registers the
    // macro output; return is steered to the owning port only.
    always_comb begin
        mem_oe   = !rst && vld_p[READ_LATENCY-2];
        ret_vld  = !rst && vld_p[READ_LATENCY-1];
        a_rvalid = ret_vld && !own_p[READ_LATENCY-1];
        b_rvalid = ret_vld &&  own_p[READ_LATENCY-1];
        a_rdata  = a_rvalid ? mem_dout : '0;
        b_rdata  = b_rvalid ? mem_dout : '0;
        busy     = !rst && (|vld_p);
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed testbench for sram_arbiter with a behavioural 16x8 sram wrapper
// (macro with registered address, plus an output register enabled by oe).
module tb_sram_arbiter;

    logic       clk;
    logic       rst;
    logic       a_req, a_we, b_req, b_we;
    logic [3:0] a_addr, b_addr;
    logic [7:0] a_wdata, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       mem_we, mem_oe, busy;
    logic [3:0] mem_addr;
    logic [7:0] mem_din, mem_dout;

    int checks = 0;
    int errors = 0;

    sram_arbiter #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .READ_LATENCY(2)) dut (
        .clk(clk), .rst(rst),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_we(mem_we), .mem_oe(mem_oe), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // sram wrapper model
    logic [7:0] mem [16];
    logic [7:0] macro_q, dout_q;
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_din;
        macro_q <= mem[mem_addr];
        if (mem_oe) dout_q <= macro_q;
    end
    assign mem_dout = dout_q;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        a_req = 0; a_we = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_we = 0; b_addr = 0; b_wdata = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        a_req = 1; b_req = 1; a_we = 1; b_we = 1; a_addr = 4'd9; b_addr = 4'd6;
        a_wdata = 8'h11; b_wdata = 8'h22;
        tick(); tick();
        #1;
        checks++; if (a_gnt !== 1'b0 || b_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt a=%b b=%b want 0 0", a_gnt, b_gnt); end
        checks++; if (mem_we !== 1'b0 || mem_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_ctl we=%b oe=%b busy=%b want 0", mem_we, mem_oe, busy); end
        checks++; if (mem_addr !== 4'd0 || mem_din !== 8'd0) begin errors++; $display("FAIL rst_bus addr=%h din=%h want 0", mem_addr, mem_din); end
        checks++; if (a_rvalid !== 1'b0 || b_rvalid !== 1'b0 || a_rdata !== 8'd0 || b_rdata !== 8'd0) begin errors++; $display("FAIL rst_ret rv=%b%b rd=%h %h want 0", a_rvalid, b_rvalid, a_rdata, b_rdata); end
        tick();
        rst = 0;
        #1;
        checks++; if (a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL post_rst_first a=%b b=%b want 1 0", a_gnt, b_gnt); end
        idle();
        tick();
        #1;
        checks++; if (mem_addr !== 4'd0 || mem_we !== 1'b0) begin errors++; $display("FAIL idle_bus addr=%h we=%b want 0 0", mem_addr, mem_we); end
        tick(); tick();
    endtask

    task automatic test_write_read();
        a_req = 1; a_we = 1; a_addr = 4'd3; a_wdata = 8'h0D;
        #1;
        checks++; if (a_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'd3 || mem_din !== 8'h0D) begin errors++; $display("FAIL wr_issue gnt=%b we=%b addr=%h din=%h want 1 1 3 0d", a_gnt, mem_we, mem_addr, mem_din); end
        tick();
        a_we = 0; a_wdata = 0;
        #1;
        checks++; if (a_gnt !== 1'b1 || mem_we !== 1'b0 || mem_oe !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rd_issue gnt=%b we=%b oe=%b busy=%b want 1 0 0 0", a_gnt, mem_we, mem_oe, busy); end
        tick();
        idle();
        #1;
        checks++; if (mem_oe !== 1'b1 || busy !== 1'b1 || a_rvalid !== 1'b0) begin errors++; $display("FAIL rd_oe oe=%b busy=%b rv=%b want 1 1 0", mem_oe, busy, a_rvalid); end
        tick();
        #1;
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 8'h0D || b_rvalid !== 1'b0) begin errors++; $display("FAIL rd_ret arv=%b ard=%h brv=%b want 1 0d 0", a_rvalid, a_rdata, b_rvalid); end
        tick();
        #1;
        checks++; if (a_rvalid !== 1'b0 || a_rdata !== 8'h00 || busy !== 1'b0) begin errors++; $display("FAIL rd_done rv=%b rd=%h busy=%b want 0 00 0", a_rvalid, a_rdata, busy); end
    endtask

    task automatic test_contention();
        logic ea, eb, eva, evb, ebusy;
        idle();
        rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 9; i++) begin
            a_req = (i < 6); b_req = (i < 6); a_addr = 4'd3; b_addr = 4'd3;
            #1;
            ea = (i < 6) && (i % 2 == 0);
            eb = (i < 6) && (i % 2 == 1);
            eva = (i >= 2) && (i <= 7) && (i % 2 == 0);
            evb = (i >= 2) && (i <= 7) && (i % 2 == 1);
            ebusy = (i >= 1) && (i <= 7);
            checks++; if (a_gnt !== ea || b_gnt !== eb) begin errors++; $display("FAIL cont_gnt[%0d] a=%b b=%b want %b %b", i, a_gnt, b_gnt, ea, eb); end
            checks++; if (a_rvalid !== eva || b_rvalid !== evb) begin errors++; $display("FAIL cont_rv[%0d] a=%b b=%b want %b %b", i, a_rvalid, b_rvalid, eva, evb); end
            checks++; if (a_rdata !== (eva ? 8'h0D : 8'h00) || b_rdata !== (evb ? 8'h0D : 8'h00)) begin errors++; $display("FAIL cont_rd[%0d] a=%h b=%h", i, a_rdata, b_rdata); end
            checks++; if (busy !== ebusy) begin errors++; $display("FAIL cont_busy[%0d] got %b want %b", i, busy, ebusy); end
            tick();
        end
        idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] fib [6];
        fib[0] = 8'd1; fib[1] = 8'd1; fib[2] = 8'd2; fib[3] = 8'd3; fib[4] = 8'd5; fib[5] = 8'd8;
        for (int i = 0; i < 6; i++) begin
            a_req = 1; a_we = 1; a_addr = 4'(i); a_wdata = fib[i];
            #1;
            checks++; if (a_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 4'(i)) begin errors++; $display("FAIL b2b_wr[%0d] gnt=%b we=%b addr=%h", i, a_gnt, mem_we, mem_addr); end
            tick();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            b_req = (i < 6); b_we = 0; b_addr = (i < 6) ? 4'(i) : 4'd0;
            #1;
            if (i < 6) begin
                checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt[%0d] got %b want 1", i, b_gnt); end
            end
            if (i >= 2) begin
                checks++; if (b_rvalid !== 1'b1 || b_rdata !== fib[i-2]) begin errors++; $display("FAIL b2b_rd[%0d] rv=%b rd=%h want 1 %h", i, b_rvalid, b_rdata, fib[i-2]); end
            end
            tick();
        end
        idle();
        #1;
        checks++; if (b_rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL b2b_end rv=%b busy=%b want 0 0", b_rvalid, busy); end
    endtask

    task automatic test_raw();
        a_req = 1; a_we = 1; a_addr = 4'd15; a_wdata = 8'h55;
        #1;
        checks++; if (a_gnt !== 1'b1 || mem_addr !== 4'd15 || mem_din !== 8'h55) begin errors++; $display("FAIL raw_wr gnt=%b addr=%h din=%h want 1 f 55", a_gnt, mem_addr, mem_din); end
        tick();
        idle();
        b_req = 1; b_we = 0; b_addr = 4'd15;
        #1;
        checks++; if (b_gnt !== 1'b1 || mem_addr !== 4'd15 || mem_we !== 1'b0) begin errors++; $display("FAIL raw_rd gnt=%b addr=%h we=%b", b_gnt, mem_addr, mem_we); end
        tick();
        idle();
        a_req = 1; a_we = 1; a_addr = 4'd15; a_wdata = 8'hAA;
        #1;
        checks++; if (a_gnt !== 1'b1 || mem_we !== 1'b1 || mem_din !== 8'hAA) begin errors++; $display("FAIL raw_ovw gnt=%b we=%b din=%h", a_gnt, mem_we, mem_din); end
        tick();
        idle();
        a_req = 1; a_we = 0; a_addr = 4'd15;
        #1;
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 8'h55 || a_rvalid !== 1'b0) begin errors++; $display("FAIL raw_ret brv=%b brd=%h arv=%b want 1 55 0", b_rvalid, b_rdata, a_rvalid); end
        tick();
        idle();
        tick();
        #1;
        checks++; if (a_rvalid !== 1'b1 || a_rdata !== 8'hAA) begin errors++; $display("FAIL raw_new rv=%b rd=%h want 1 aa", a_rvalid, a_rdata); end
        tick();
    endtask

    task automatic test_reset_midflight();
        b_req = 1; b_we = 0; b_addr = 4'd2;
        #1;
        checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt got %b want 1", b_gnt); end
        tick();
        idle();
        rst = 1;
        #1;
        checks++; if (b_gnt !== 1'b0 || busy !== 1'b0 || mem_oe !== 1'b0) begin errors++; $display("FAIL mid_rst gnt=%b busy=%b oe=%b want 0 0 0", b_gnt, busy, mem_oe); end
        tick();
        rst = 0;
        #1;
        checks++; if (b_rvalid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_norv rv=%b busy=%b want 0 0", b_rvalid, busy); end
        tick();
        a_req = 1; b_req = 1; a_addr = 4'd1; b_addr = 4'd2;
        #1;
        checks++; if (b_rvalid !== 1'b0 || a_gnt !== 1'b1 || b_gnt !== 1'b0) begin errors++; $display("FAIL mid_conflict brv=%b a=%b b=%b want 0 1 0", b_rvalid, a_gnt, b_gnt); end
        tick();
        a_req = 0;
        #1;
        checks++; if (b_gnt !== 1'b1) begin errors++; $display("FAIL mid_second got %b want 1", b_gnt); end
        tick();
        idle();
        tick(); tick(); tick();
    endtask

    task automatic test_held();
        int wr_hits;
        int gnt_cycle;
        wr_hits = 0; gnt_cycle = -1;
        b_req = 1; b_we = 1; b_addr = 4'd7; b_wdata = 8'h21;
        for (int i = 0; i < 4; i++) begin
            a_req = 1; a_we = 0; a_addr = 4'd0;
            #1;
            if (mem_we === 1'b1 && mem_addr === 4'd7) wr_hits++;
            if (b_gnt === 1'b1) begin
                gnt_cycle = i;
                checks++; if (mem_din !== 8'h21 || a_gnt !== 1'b0) begin errors++; $display("FAIL held_issue din=%h agnt=%b want 21 0", mem_din, a_gnt); end
            end
            tick();
            if (gnt_cycle >= 0) begin
                b_req = 0; b_we = 0; b_wdata = 0;
            end
        end
        idle();
        checks++; if (gnt_cycle < 0 || gnt_cycle > 1) begin errors++; $display("FAIL held_wait grant cycle %0d want 0..1", gnt_cycle); end
        checks++; if (wr_hits != 1) begin errors++; $display("FAIL held_once writes %0d want 1", wr_hits); end
        tick(); tick();
        b_req = 1; b_we = 0; b_addr = 4'd7;
        tick();
        idle();
        tick();
        #1;
        checks++; if (b_rvalid !== 1'b1 || b_rdata !== 8'h21) begin errors++; $display("FAIL held_read rv=%b rd=%h want 1 21", b_rvalid, b_rdata); end
        tick();
    endtask

    initial begin
        idle();
        rst = 1;
        test_reset();
        test_write_read();
        test_contention();
        test_back_to_back();
        test_raw();
        test_reset_midflight();
        test_held();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
